// File: rtl/if_fetch_ctrl_pkg.sv
// Shared IF-stage types: word address, fetch sequencer states
// and the reset vector.
package if_fetch_ctrl_pkg;

  typedef logic [31:2] word_addr_t;

  localparam word_addr_t START_ADDR = 30'h0000BFF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD,
    HOLD
  } if_state_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction memory request/ack bus between the fetch
// sequencer (master) and instruction memory (slave).
interface if_fetch_ctrl_if;
  import if_fetch_ctrl_pkg::*;

  logic        req;
  word_addr_t  addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

// File: rtl/if_fetch_ctrl_npc_sel.sv
// Redirect priority (exception over branch) and next-PC /
// PC write-enable generation for the PC register.
module if_npc_sel
  import if_fetch_ctrl_pkg::*;
(
  input  word_addr_t i_pc,
  input  logic       i_fetch_ack,
  input  logic       i_br_valid,
  input  word_addr_t i_br_target,
  input  logic       i_exc_valid,
  input  word_addr_t i_exc_vector,
  output logic       o_redir,
  output word_addr_t o_target,
  output word_addr_t o_npc,
  output logic       o_pc_write
);

  assign o_redir = i_exc_valid | i_br_valid;

  assign o_target = i_exc_valid ? i_exc_vector
                                : i_br_target;

  assign o_npc = o_redir ? o_target
                         : i_pc + 30'd1;

  assign o_pc_write = o_redir | i_fetch_ack;

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: one outstanding imem request,
// redirect handling, stale-fetch discard and IF/ID register.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter word_addr_t START_ADDR =
    if_fetch_ctrl_pkg::START_ADDR,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  word_addr_t         pc,
  output word_addr_t         npc,
  output logic               pc_write,
  if_fetch_ctrl_if.master    imem,
  input  logic               stall,
  input  logic               br_valid,
  input  word_addr_t         br_target,
  input  logic               exc_valid,
  input  word_addr_t         exc_vector,
  output logic               ir_valid,
  output logic [31:0]        ir_out,
  output word_addr_t         ir_pc,
  output logic [CNT_W-1:0]   fetch_cnt
);

  if_state_t        r_state;
  if_state_t        w_state_nxt;
  word_addr_t       r_addr;
  word_addr_t       w_addr_nxt;
  logic             r_ir_valid;
  logic             w_ir_valid_nxt;
  logic [31:0]      r_ir_out;
  word_addr_t       r_ir_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             w_capture;
  logic             w_fetch_ack;
  logic             w_redir;
  word_addr_t       w_target;
  word_addr_t       w_npc;

  assign w_fetch_ack = (r_state == FETCH) & imem.ack;

  if_npc_sel u_npc_sel (
    .i_pc         (pc),
    .i_fetch_ack  (w_fetch_ack),
    .i_br_valid   (br_valid),
    .i_br_target  (br_target),
    .i_exc_valid  (exc_valid),
    .i_exc_vector (exc_vector),
    .o_redir      (w_redir),
    .o_target     (w_target),
    .o_npc        (w_npc),
    .o_pc_write   (pc_write)
  );

  assign npc = w_npc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_ir_valid_nxt = r_ir_valid;
    w_capture      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
        w_addr_nxt  = w_redir ? w_target : pc;
      end
      FETCH: begin
        unique case (1'b1)
          imem.ack & ~w_redir: begin
            w_capture      = 1'b1;
            w_ir_valid_nxt = 1'b1;
            w_addr_nxt     = w_npc;
            if (stall) w_state_nxt = HOLD;
          end
          imem.ack & w_redir: begin
            w_ir_valid_nxt = 1'b0;
            w_addr_nxt     = w_target;
          end
          ~imem.ack & w_redir: begin
            w_ir_valid_nxt = 1'b0;
            w_state_nxt    = DISCARD;
          end
          default: begin
            if (!stall) w_ir_valid_nxt = 1'b0;
          end
        endcase
      end
      DISCARD: begin
        w_ir_valid_nxt = 1'b0;
        if (imem.ack) begin
          w_state_nxt = FETCH;
          w_addr_nxt  = w_redir ? w_target : pc;
        end
      end
      HOLD: begin
        if (w_redir) begin
          w_ir_valid_nxt = 1'b0;
          w_addr_nxt     = w_target;
          w_state_nxt    = FETCH;
        end else if (!stall) begin
          w_ir_valid_nxt = 1'b0;
          w_addr_nxt     = pc;
          w_state_nxt    = FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Data regs: request address and IF/ID contents
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr     <= START_ADDR;
      r_ir_valid <= 1'b0;
      r_ir_out   <= '0;
      r_ir_pc    <= START_ADDR;
      r_cnt      <= '0;
    end else begin
      r_addr     <= w_addr_nxt;
      r_ir_valid <= w_ir_valid_nxt;
      if (w_capture) begin
        r_ir_out <= imem.rdata;
        r_ir_pc  <= r_addr;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign imem.req  = (r_state == FETCH) |
                     (r_state == DISCARD);
  assign imem.addr = r_addr;
  assign ir_valid  = r_ir_valid;
  assign ir_out    = r_ir_out;
  assign ir_pc     = r_ir_pc;
  assign fetch_cnt = r_cnt;

endmodule
